// File: rtl/sdm_tx_pkg.sv
// sdm_tx_pkg - shared types and helpers for the SDM transmit network interface.
//   tx_state_e : launch FSM states (idle / data phase / return-to-zero).
//   enc1of4    : maps a 2-bit symbol to its one-hot 1-of-4 rail code.
package sdm_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RTZ  = 2'd2
  } tx_state_e;

  function automatic logic [3:0] enc1of4(input logic [1:0] v);
    logic [3:0] c;
    c    = '0;
    c[v] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sdm_tx_fifo.sv
// sdm_tx_fifo - small synchronous FIFO holding flits awaiting launch.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset (empties the FIFO)
//   push_i       : write data_i this cycle (ignored when full)
//   data_i       : W-bit entry to write
//   pop_i        : drop the head entry this cycle (ignored when empty)
//   data_o       : head entry (valid while not empty)
//   empty_o      : registered empty flag
//   full_next_o  : full flag as it will be after this edge
module sdm_tx_fifo #(
  parameter int unsigned W  = 9,
  parameter int unsigned FD = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_next_o
);

  localparam int unsigned AW = $clog2(FD);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FD);

  logic [W-1:0]  mem_q [FD];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign full_next_o = (count_d == FULL_CNT);

  // Pointers wrap naturally because FD is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;

endmodule

// File: rtl/sdm_tx_ni.sv
// sdm_tx_ni - synchronous-to-asynchronous transmit network interface.
// Takes clocked flits (valid/ready + eof), buffers them, and launches each one
// as a 1-of-4 four-phase return-to-zero code, completing against an async ack.
// Ports:
//   clk, rst_n   : clock (rising) and asynchronous active-low reset
//   din, din_eof : flit payload and end-of-frame flag
//   din_valid    : flit offered; accepted when din_ready is high
//   din_ready    : registered FIFO-not-full
//   o0..o3       : rail r of each of the SCN 1-of-4 sub-channels
//   o4           : eof rail
//   oa           : asynchronous acknowledge from the router port
//   idle         : FIFO empty, FSM idle and synchronised ack low (registered)
module sdm_tx_ni
  import sdm_tx_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned SCN  = DW / 2,
  parameter int unsigned FD   = 4,
  parameter int unsigned SYNC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  din,
  input  logic           din_eof,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           oa,
  output logic           idle
);

  localparam int unsigned HW = $clog2(SYNC + 2);
  localparam logic [HW-1:0] HOLD_DONE = HW'(SYNC + 1);

  tx_state_e            state_q;
  logic [3:0][SCN-1:0]  rails_q;
  logic                 eof_q;
  logic                 idle_q;
  logic                 din_ready_q;
  logic [SYNC-1:0]      ack_sync_q;
  logic [HW-1:0]        hold_q;

  logic                 ack_s;
  logic                 ack_early;
  logic                 hold_done;
  logic                 push;
  logic                 launch;
  logic [DW:0]          head;
  logic                 fifo_empty;
  logic                 fifo_full_next;
  logic [3:0][SCN-1:0]  head_rails;

  // Ack synchroniser: ack_s is the last stage. ack_early is the value ack_s
  // takes at the coming edge; the DATA/RTZ transitions use it so the rails
  // change on the same edge that ack_s does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC-2:0], oa};
  end

  assign ack_s     = ack_sync_q[SYNC-1];
  assign ack_early = ack_sync_q[SYNC-2];

  // Hold-off after reset so a stale high ack reaches ack_s before any launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          hold_q <= '0;
    else if (!hold_done) hold_q <= hold_q + 1'b1;
  end

  assign hold_done = (hold_q == HOLD_DONE);

  assign push = din_valid & din_ready_q;

  sdm_tx_fifo #(
    .W  (DW + 1),
    .FD (FD)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .data_i      ({din_eof, din}),
    .pop_i       (launch),
    .data_o      (head),
    .empty_o     (fifo_empty),
    .full_next_o (fifo_full_next)
  );

  // Ready follows the post-edge fill level, so the push that fills the FIFO
  // drops ready on the same edge and a pop re-raises it on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_ready_q <= 1'b0;
    else        din_ready_q <= ~fifo_full_next;
  end

  always_comb begin
    logic [3:0] code;
    head_rails = '0;
    code       = '0;
    for (int unsigned k = 0; k < SCN; k++) begin
      code = enc1of4(head[2*k +: 2]);
      for (int unsigned r = 0; r < 4; r++) begin
        head_rails[r][k] = code[r];
      end
    end
  end

  // From IDLE a launch waits for the fully synchronised ack to be low; from
  // RTZ the next head goes out as soon as the falling ack arrives.
  always_comb begin
    launch = 1'b0;
    if (hold_done && !fifo_empty) begin
      if (state_q == ST_IDLE) launch = ~ack_s;
      else if (state_q == ST_RTZ) launch = ~ack_early;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rails_q <= '0;
      eof_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      idle_q <= fifo_empty & (state_q == ST_IDLE) & ~ack_s;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            rails_q <= head_rails;
            eof_q   <= head[DW];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // A falling ack here was never seen high; it is simply ignored.
          if (ack_early) begin
            rails_q <= '0;
            eof_q   <= 1'b0;
            state_q <= ST_RTZ;
          end
        end
        ST_RTZ: begin
          if (!ack_early) begin
            if (launch) begin
              rails_q <= head_rails;
              eof_q   <= head[DW];
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          rails_q <= '0;
          eof_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o0        = rails_q[0];
  assign o1        = rails_q[1];
  assign o2        = rails_q[2];
  assign o3        = rails_q[3];
  assign o4        = eof_q;
  assign din_ready = din_ready_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_sdm_tx_ni.sv
// tb_sdm_tx_ni - directed self-checking bench for sdm_tx_ni (DW=8, FD=4, SYNC=2).
// Rails are viewed as one 17-bit word {o4, o3, o2, o1, o0}.
module tb_sdm_tx_ni;

  localparam int unsigned DW   = 8;
  localparam int unsigned SCN  = 4;
  localparam int unsigned FD   = 4;
  localparam int unsigned SYNC = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [DW-1:0]  din = '0;
  logic           din_eof = 1'b0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [SCN-1:0] o0, o1, o2, o3;
  logic           o4;
  logic           oa;
  logic           idle;

  logic           oa_man = 1'b0;
  logic           ack_auto = 1'b0;
  logic           oa_auto_q = 1'b0;
  logic [16:0]    rails;

  int total = 0;
  int bad   = 0;

  assign rails = {o4, o3, o2, o1, o0};
  assign oa    = ack_auto ? oa_auto_q : oa_man;

  always #5 clk = ~clk;

  // Automatic receiver: ack follows the rails one cycle later.
  always @(posedge clk) oa_auto_q <= |rails;

  sdm_tx_ni #(
    .DW   (DW),
    .SCN  (SCN),
    .FD   (FD),
    .SYNC (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_eof   (din_eof),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .o4        (o4),
    .oa        (oa),
    .idle      (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_zero(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((rails !== '0) && (n < 40));
    chk({tag, "_spacer_to"}, 32'(rails === '0), 32'd1);
  endtask

  task automatic wait_nz(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((rails === '0) && (n < 40));
    chk({tag, "_launch_to"}, 32'(rails !== '0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((idle !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  // Manual four-phase cycle: ack up, see spacer, ack down, see next code.
  task automatic hs(input string tag, input logic [16:0] exp);
    int n;
    oa_man = 1'b1;
    wait_zero(tag, n);
    oa_man = 1'b0;
    wait_nz(tag, n);
    chk(tag, 32'(rails), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    logic [7:0] bp [6];
    bp = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'hE4, 8'h1B};

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rails", 32'(rails), 32'h0);
    chk("rst_ready", 32'(din_ready), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("post_rst_ready", 32'(din_ready), 32'd1);
    chk("post_rst_rails", 32'(rails), 32'h0);

    // 1: encoding of B4, ack rise -> spacer after SYNC edges, idle SYNC+1 after fall
    din = 8'hB4; din_eof = 1'b0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("t1_no_early_launch", 32'(rails), 32'h0);
    tick();
    chk("t1_code_B4", 32'(rails), 32'h04821);
    chk("t1_not_idle", 32'(idle), 32'd0);
    oa_man = 1'b1;
    tick();
    chk("t1_hold_code", 32'(rails), 32'h04821);
    tick();
    chk("t1_spacer", 32'(rails), 32'h0);
    oa_man = 1'b0;
    tick(); tick();
    chk("t1_idle_early", 32'(idle), 32'd0);
    tick();
    chk("t1_idle", 32'(idle), 32'd1);

    // 2: three-flit packet with automatic ack
    ack_auto = 1'b1;
    din = 8'h00; din_eof = 1'b0; din_valid = 1'b1;
    tick();
    din = 8'hFF;
    tick();
    din = 8'h5A; din_eof = 1'b1;
    tick();
    din_valid = 1'b0; din_eof = 1'b0;
    chk("t2_code_00", 32'(rails), 32'h0000F);
    wait_zero("t2_a", n);
    wait_nz("t2_b", n2);
    chk("t2_code_FF", 32'(rails), 32'h0F000);
    chk("t2_period_1", 32'(n + n2 + 1), 32'(2*SYNC + 2));
    wait_zero("t2_c", n);
    wait_nz("t2_d", n2);
    chk("t2_code_5A_eof", 32'(rails), 32'h103C0);
    chk("t2_period_2", 32'(n + n2), 32'(2*SYNC + 2));
    wait_zero("t2_e", n);
    wait_idle("t2");
    ack_auto = 1'b0;
    oa_man   = 1'b0;

    // 3: back-pressure with ack held low
    for (int i = 0; i < 5; i++) begin
      din = bp[i]; din_eof = 1'b0; din_valid = 1'b1;
      chk($sformatf("t3_ready_%0d", i), 32'(din_ready), 32'd1);
      tick();
    end
    din = bp[5]; din_eof = 1'b1;
    chk("t3_full_ready", 32'(din_ready), 32'd0);
    chk("t3_first_code", 32'(rails), 32'h0000F);
    tick(); tick(); tick();
    chk("t3_stall_ready", 32'(din_ready), 32'd0);
    chk("t3_stall_code", 32'(rails), 32'h0000F);
    oa_man = 1'b1;
    wait_zero("t3_a", n);
    chk("t3_spacer_lat", 32'(n), 32'(SYNC));
    chk("t3_ready_in_rtz", 32'(din_ready), 32'd0);
    oa_man = 1'b0;
    wait_nz("t3_b", n);
    chk("t3_relaunch_lat", 32'(n), 32'(SYNC));
    chk("t3_code_55", 32'(rails), 32'h000F0);
    chk("t3_ready_back", 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0; din_eof = 1'b0;
    hs("t3_code_AA", 17'h00F00);
    hs("t3_code_FF", 17'h0F000);
    hs("t3_code_E4", 17'h08421);
    hs("t3_code_1B_eof", 17'h11248);
    oa_man = 1'b1;
    wait_zero("t3_c", n);
    oa_man = 1'b0;
    wait_idle("t3");

    // 4: stale ack across reset
    rst_n = 1'b0; oa_man = 1'b1;
    #1;
    chk("t4_rst_rails", 32'(rails), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    din = 8'h55; din_eof = 1'b0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_no_launch", 32'(rails), 32'h0);
    chk("t4_not_idle", 32'(idle), 32'd0);
    oa_man = 1'b0;
    tick(); tick();
    chk("t4_still_waiting", 32'(rails), 32'h0);
    tick();
    chk("t4_launch_55", 32'(rails), 32'h000F0);
    oa_man = 1'b1;
    wait_zero("t4_a", n);
    oa_man = 1'b0;
    wait_idle("t4");

    // 5: reset during DATA with a flit still queued
    din = 8'hAA; din_eof = 1'b0; din_valid = 1'b1;
    tick();
    din = 8'hFF;
    tick();
    din_valid = 1'b0;
    chk("t5_code_AA", 32'(rails), 32'h00F00);
    rst_n = 1'b0;
    #1;
    chk("t5_async_rails", 32'(rails), 32'h0);
    chk("t5_async_ready", 32'(din_ready), 32'd0);
    chk("t5_async_idle", 32'(idle), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t5_ready", 32'(din_ready), 32'd1);
    chk("t5_rails_quiet", 32'(rails), 32'h0);
    din = 8'hE4; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    chk("t5_holdoff", 32'(rails), 32'h0);
    tick();
    chk("t5_code_E4", 32'(rails), 32'h08421);
    oa_man = 1'b1;
    wait_zero("t5_a", n);
    oa_man = 1'b0;
    wait_idle("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
